// File: rtl/spike_out_serializer.sv
// Output-spike serializer for the SNN core.
// Each core result word is tagged with an end-of-frame flag from the output
// grid position (oh, ow, ot) and buffered in a small FIFO. The buffered words
// are then streamed LSB chunk first as IO_WIDTH-bit beats over a valid/ready
// port. BP warns the input controller when the buffer is close to full, and
// OVF latches when a word has to be dropped.
module spike_out_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int IO_WIDTH   = 8,
  parameter int DEPTH      = 4,
  parameter int HW_WIDTH   = 5,
  parameter int T_WIDTH    = 5,
  parameter int I          = 4,
  parameter int J          = 4
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  CORE_VALID,
  input  logic [DATA_WIDTH-1:0] CORE_DATA,
  input  logic [HW_WIDTH-1:0]   HW,
  input  logic [T_WIDTH-1:0]    T,
  output logic                  OUT_VALID,
  output logic [IO_WIDTH-1:0]   OUT_DATA,
  output logic                  OUT_LAST,
  input  logic                  OUT_READY,
  output logic                  BP,
  output logic                  OVF
);

  localparam int BEATS  = DATA_WIDTH / IO_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_NEAR  = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_SEND
  } state_t;

  // FIFO storage: {last flag, word}
  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  // Output grid position of the next word to be accepted
  logic [T_WIDTH-1:0]    r_ot;
  logic [HW_WIDTH-1:0]   r_ow;
  logic [HW_WIDTH-1:0]   r_oh;

  // Serializer state
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_word_last;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_bp;
  logic                  r_ovf;

  logic                  w_full;
  logic                  w_nempty;
  logic                  w_pop;
  logic                  w_push;
  logic [CNT_W-1:0]      w_count_next;
  logic [HW_WIDTH-1:0]   w_ow_max;
  logic [HW_WIDTH-1:0]   w_oh_max;
  logic                  w_ot_wrap;
  logic                  w_ow_wrap;
  logic                  w_oh_wrap;
  logic                  w_word_last;
  logic [DATA_WIDTH:0]   w_head;
  logic [BEAT_W-1:0]     w_beat_inc;

  assign w_full   = (r_count == CNT_FULL);
  assign w_nempty = (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];

  // A word leaves the FIFO when the serializer is idle, or when it is about
  // to finish the current word; the latter lets a full FIFO accept a write.
  assign w_pop  = w_nempty &&
                  ((r_state == S_IDLE) ||
                   (OUT_READY && (r_beat == LAST_BEAT)));
  assign w_push = CORE_VALID && (!w_full || w_pop);

  // Output grid extents: OH = H-(I-1), OW = W-(J-1)
  assign w_oh_max    = HW - HW_WIDTH'(I - 1);
  assign w_ow_max    = HW - HW_WIDTH'(J - 1);
  assign w_ot_wrap   = (r_ot == T);
  assign w_ow_wrap   = (r_ow == w_ow_max);
  assign w_oh_wrap   = (r_oh == w_oh_max);
  assign w_word_last = w_ot_wrap && w_ow_wrap && w_oh_wrap;

  assign w_beat_inc = r_beat + 1'b1;

  // Occupancy after the coming edge, used for count and registered BP
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block free of latches.
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // FIFO data array write
  // NOTE: the storage array has no reset; the count/pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_word_last, CORE_DATA};
    end
  end

  // FIFO pointers, occupancy, back-pressure and sticky overflow
  always_ff @(posedge CLK or negedge RSTB) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!RSTB) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bp     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_bp    <= (w_count_next >= CNT_NEAR);
      if (CORE_VALID && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Grid position advances only on accepted words: ot innermost, then ow, then oh
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_ot <= '0;
      r_ow <= '0;
      r_oh <= '0;
    end else if (w_push) begin
      if (w_ot_wrap) begin
        r_ot <= '0;
        if (w_ow_wrap) begin
          r_ow <= '0;
          r_oh <= w_oh_wrap ? '0 : r_oh + 1'b1;
        end else begin
          r_ow <= r_ow + 1'b1;
        end
      end else begin
        r_ot <= r_ot + 1'b1;
      end
    end
  end

  // Serializer FSM: load a word on pop, then shift out one beat per handshake
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_beat      <= '0;
      r_word_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_pop) begin
      r_state     <= S_SEND;
      r_shift     <= w_head[DATA_WIDTH-1:0];
      r_beat      <= '0;
      r_word_last <= w_head[DATA_WIDTH];
      r_out_valid <= 1'b1;
      r_out_last  <= (LAST_BEAT == '0) && w_head[DATA_WIDTH];
    end else if ((r_state == S_SEND) && OUT_READY) begin
      if (r_beat == LAST_BEAT) begin
        r_state     <= S_IDLE;
        r_shift     <= '0;
        r_beat      <= '0;
        r_word_last <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_shift    <= r_shift >> IO_WIDTH;
        r_beat     <= w_beat_inc;
        r_out_last <= (w_beat_inc == LAST_BEAT) && r_word_last;
      end
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_shift[IO_WIDTH-1:0];
  assign OUT_LAST  = r_out_last;
  assign BP        = r_bp;
  assign OVF       = r_ovf;

endmodule
